// File: rtl/datapath_p.sv
// Purpose: word-wide datapath (bus, 8-entry register file, ALU, address adder, PC/IR/MAR/MDR, NZP/BEN) with a memory FSM.
// Latency: register loads land on the next rising Clk; start -> mem_req next cycle; read data in MDR one cycle after mem_ack.
// Backpressure: mem_req holds until mem_ack or TIMEOUT abort; starts while not idle and acks outside REQ are dropped.
module datapath_p #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             Reset_al,
    input  logic             LD_PC,
    input  logic             LD_IR,
    input  logic             LD_MAR,
    input  logic             LD_MDR,
    input  logic             LD_BEN,
    input  logic             LD_CC,
    input  logic             LD_REG,
    input  logic             GateALU,
    input  logic             GatePC,
    input  logic             GateMARMUX,
    input  logic             GateMDR,
    input  logic [1:0]       PCMUX,
    input  logic [1:0]       ADDR2MUX,
    input  logic [1:0]       ALUK,
    input  logic             ADDR1MUX,
    input  logic             SR1MUX,
    input  logic             DRMUX,
    input  logic             MEM_RD,
    input  logic             MEM_WR,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             MEM_BUSY,
    output logic             MEM_ERR,
    output logic             BEN,
    output logic [2:0]       NZP,
    output logic [WIDTH-1:0] IR,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] MAR,
    output logic [WIDTH-1:0] MDR
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} mem_state_t;

    mem_state_t       state, state_nxt;
    logic [7:0]       tmo_cnt;
    logic             start_ok, start_bad, to_err, rd_done;
    logic [WIDTH-1:0] regs [8];
    logic [WIDTH-1:0] sr1_dat, sr2_dat, alu_b, alu_dat;
    logic [WIDTH-1:0] addr1, addr2, adder_dat, bus;
    logic [2:0]       sr1_idx, dr_idx;
    logic             unused_ir;

    // Opcode bits above the operand fields are only meaningful to the controller.
    assign unused_ir = ^IR[WIDTH-1:12];

    assign sr1_idx = SR1MUX ? IR[8:6] : IR[11:9];
    assign dr_idx  = DRMUX ? 3'd7 : IR[11:9];
    assign sr1_dat = regs[sr1_idx];
    assign sr2_dat = regs[IR[2:0]];
    assign alu_b   = IR[5] ? {{(WIDTH-5){IR[4]}}, IR[4:0]} : sr2_dat;
    assign addr1   = ADDR1MUX ? PC : sr1_dat;

    // ALU function and address-adder offset selection.
    always_comb begin
        alu_dat = sr1_dat;
        addr2   = '0;
        case (ALUK)
            2'd0:    alu_dat = sr1_dat + alu_b;
            2'd1:    alu_dat = sr1_dat & alu_b;
            2'd2:    alu_dat = ~sr1_dat;
            default: alu_dat = sr1_dat;
        endcase
        case (ADDR2MUX)
            2'd0:    addr2 = {{(WIDTH-11){IR[10]}}, IR[10:0]};
            2'd1:    addr2 = {{(WIDTH-9){IR[8]}}, IR[8:0]};
            2'd2:    addr2 = {{(WIDTH-6){IR[5]}}, IR[5:0]};
            default: addr2 = '0;
        endcase
    end

    assign adder_dat = addr1 + addr2;

    // Single shared bus with fixed driver priority; undriven bus reads as zero.
    always_comb begin
        bus = '0;
        if (GateALU)         bus = alu_dat;
        else if (GatePC)     bus = PC;
        else if (GateMARMUX) bus = adder_dat;
        else if (GateMDR)    bus = MDR;
    end

    // Register file write port.
    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (LD_REG) begin
            regs[dr_idx] <= bus;
        end
    end

    // Architectural registers; a read completion takes priority over a bus load of MDR.
    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            PC  <= '0;
            IR  <= '0;
            MAR <= '0;
            MDR <= '0;
            NZP <= 3'b010;
            BEN <= 1'b0;
        end else begin
            if (LD_PC) begin
                case (PCMUX)
                    2'd0:    PC <= bus;
                    2'd1:    PC <= adder_dat;
                    2'd2:    PC <= PC + WIDTH'(1);
                    default: PC <= PC;
                endcase
            end
            if (LD_IR)  IR  <= bus;
            if (LD_MAR) MAR <= bus;
            if (rd_done)     MDR <= mem_rdata;
            else if (LD_MDR) MDR <= bus;
            if (LD_CC)  NZP <= {bus[WIDTH-1], bus == '0, !bus[WIDTH-1] && (bus != '0)};
            if (LD_BEN) BEN <= (IR[11] & NZP[2]) | (IR[10] & NZP[1]) | (IR[9] & NZP[0]);
        end
    end

    // Memory FSM state register.
    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) state <= IDLE;
        else           state <= state_nxt;
    end

    // Memory FSM next state and the one-cycle event strobes.
    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        to_err    = 1'b0;
        case (state)
            IDLE: begin
                if (MEM_RD ^ MEM_WR) begin
                    state_nxt = REQ;
                    start_ok  = 1'b1;
                end else if (MEM_RD && MEM_WR) begin
                    start_bad = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_nxt = DONE;
                end else if (tmo_cnt == 8'(TIMEOUT)) begin
                    state_nxt = ERR;
                    to_err    = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_done = (state == REQ) && mem_ack && !mem_we;

    // Request direction, timeout counter and sticky error flag.
    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            mem_we  <= 1'b0;
            tmo_cnt <= '0;
            MEM_ERR <= 1'b0;
        end else begin
            if (start_ok) begin
                mem_we  <= MEM_WR;
                tmo_cnt <= '0;
            end else if (state == REQ) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (start_ok)                 MEM_ERR <= 1'b0;
            else if (start_bad || to_err) MEM_ERR <= 1'b1;
        end
    end

    assign mem_req   = (state == REQ);
    assign MEM_BUSY  = (state == REQ) || (state == DONE);
    assign mem_addr  = MAR;
    assign mem_wdata = MDR;

endmodule

// File: tb/tb_datapath_p.sv
// Purpose: randomized and directed bench for datapath_p against a transaction-level reference model.
// Latency: checks architectural state one edge after each control word; memory requests checked at their first cycle.
// Backpressure: bench acks memory after a chosen delay or never, exercising the timeout abort.
module tb_datapath_p;
    localparam int TO = 3;

    logic        Clk = 1'b0;
    logic        Reset_al = 1'b0;
    logic        LD_PC = 0, LD_IR = 0, LD_MAR = 0, LD_MDR = 0, LD_BEN = 0, LD_CC = 0, LD_REG = 0;
    logic        GateALU = 0, GatePC = 0, GateMARMUX = 0, GateMDR = 0;
    logic [1:0]  PCMUX = 0, ADDR2MUX = 0, ALUK = 0;
    logic        ADDR1MUX = 0, SR1MUX = 0, DRMUX = 0;
    logic        MEM_RD = 0, MEM_WR = 0, mem_ack = 0;
    logic [15:0] mem_rdata = 0;
    logic [31:0] rdata32;

    logic        mem_req, mem_we, MEM_BUSY, MEM_ERR, BEN;
    logic [2:0]  NZP;
    logic [15:0] mem_addr, mem_wdata, IR, PC, MAR, MDR;

    logic        u32_unused_req, u32_unused_we, u32_unused_busy, u32_unused_err, u32_unused_ben;
    logic [31:0] u32_unused_addr, u32_unused_wdata, u32_unused_ir, u32_unused_pc, u32_unused_mar;
    logic [31:0] mdr32;
    logic [2:0]  nzp32;

    assign rdata32 = {16'h0000, mem_rdata};

    always #5 Clk = ~Clk;

    datapath_p #(.WIDTH(16), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset_al(Reset_al),
        .LD_PC(LD_PC), .LD_IR(LD_IR), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_REG(LD_REG),
        .GateALU(GateALU), .GatePC(GatePC), .GateMARMUX(GateMARMUX), .GateMDR(GateMDR),
        .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX), .DRMUX(DRMUX),
        .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .MEM_BUSY(MEM_BUSY), .MEM_ERR(MEM_ERR), .BEN(BEN), .NZP(NZP),
        .IR(IR), .PC(PC), .MAR(MAR), .MDR(MDR)
    );

    datapath_p #(.WIDTH(32), .TIMEOUT(TO)) u32 (
        .Clk(Clk), .Reset_al(Reset_al),
        .LD_PC(LD_PC), .LD_IR(LD_IR), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_REG(LD_REG),
        .GateALU(GateALU), .GatePC(GatePC), .GateMARMUX(GateMARMUX), .GateMDR(GateMDR),
        .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX), .DRMUX(DRMUX),
        .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .mem_ack(mem_ack), .mem_rdata(rdata32),
        .mem_req(u32_unused_req), .mem_we(u32_unused_we), .mem_addr(u32_unused_addr),
        .mem_wdata(u32_unused_wdata), .MEM_BUSY(u32_unused_busy), .MEM_ERR(u32_unused_err),
        .BEN(u32_unused_ben), .NZP(nzp32), .IR(u32_unused_ir), .PC(u32_unused_pc),
        .MAR(u32_unused_mar), .MDR(mdr32)
    );

    typedef struct packed {
        logic ld_pc, ld_ir, ld_mar, ld_mdr, ld_ben, ld_cc, ld_reg;
        logic g_alu, g_pc, g_mm, g_mdr;
        logic [1:0] pcmux, addr2mux, aluk;
        logic addr1mux, sr1mux, drmux;
    } ctl_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    req_t sb[$];

    // Reference model state
    logic [15:0] m_reg [8];
    logic [15:0] m_pc, m_ir, m_mar, m_mdr;
    logic [2:0]  m_nzp;
    logic        m_ben, m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
        m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0;
        m_nzp = 3'b010; m_ben = 0; m_err = 0;
    endtask

    function automatic logic [15:0] sx(input logic [15:0] v, input int n);
        int val;
        val = int'(v) % (1 << n);
        if (val >= (1 << (n - 1))) val = val - (1 << n);
        return 16'(val);
    endfunction

    task automatic model_step(input ctl_t c);
        logic [15:0] a, b, alu, adder, off, bus;
        int          dr;
        logic        ben_n;
        a = m_reg[c.sr1mux ? m_ir[8:6] : m_ir[11:9]];
        b = m_ir[5] ? sx(m_ir, 5) : m_reg[m_ir[2:0]];
        case (c.aluk)
            2'd0:    alu = a + b;
            2'd1:    alu = a & b;
            2'd2:    alu = ~a;
            default: alu = a;
        endcase
        case (c.addr2mux)
            2'd0:    off = sx(m_ir, 11);
            2'd1:    off = sx(m_ir, 9);
            2'd2:    off = sx(m_ir, 6);
            default: off = 16'h0;
        endcase
        adder = (c.addr1mux ? m_pc : a) + off;
        bus = c.g_alu ? alu : c.g_pc ? m_pc : c.g_mm ? adder : c.g_mdr ? m_mdr : 16'h0;
        ben_n = (m_ir[11] && m_nzp[2]) || (m_ir[10] && m_nzp[1]) || (m_ir[9] && m_nzp[0]);
        dr = c.drmux ? 7 : int'(m_ir[11:9]);
        if (c.ld_ben) m_ben = ben_n;
        if (c.ld_cc)  m_nzp = (bus == 16'h0) ? 3'b010 : (bus >= 16'h8000) ? 3'b100 : 3'b001;
        if (c.ld_reg) m_reg[dr] = bus;
        if (c.ld_pc) begin
            case (c.pcmux)
                2'd0:    m_pc = bus;
                2'd1:    m_pc = adder;
                2'd2:    m_pc = m_pc + 16'd1;
                default: m_pc = m_pc;
            endcase
        end
        if (c.ld_ir)  m_ir  = bus;
        if (c.ld_mar) m_mar = bus;
        if (c.ld_mdr) m_mdr = bus;
    endtask

    task automatic drive(input ctl_t c);
        LD_PC = c.ld_pc; LD_IR = c.ld_ir; LD_MAR = c.ld_mar; LD_MDR = c.ld_mdr;
        LD_BEN = c.ld_ben; LD_CC = c.ld_cc; LD_REG = c.ld_reg;
        GateALU = c.g_alu; GatePC = c.g_pc; GateMARMUX = c.g_mm; GateMDR = c.g_mdr;
        PCMUX = c.pcmux; ADDR2MUX = c.addr2mux; ALUK = c.aluk;
        ADDR1MUX = c.addr1mux; SR1MUX = c.sr1mux; DRMUX = c.drmux;
    endtask

    task automatic check_state();
        chk("pc", 32'(PC), 32'(m_pc));
        chk("ir", 32'(IR), 32'(m_ir));
        chk("mar", 32'(MAR), 32'(m_mar));
        chk("mdr", 32'(MDR), 32'(m_mdr));
        chk("nzp", 32'(NZP), 32'(m_nzp));
        chk("ben", 32'(BEN), 32'(m_ben));
        chk("mem_err", 32'(MEM_ERR), 32'(m_err));
        chk("idle_busy", 32'(MEM_BUSY), 0);
    endtask

    // One register-transfer cycle; stray acks while idle must be ignored.
    task automatic rt(input ctl_t c);
        drive(c);
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        model_step(c);
        @(posedge Clk); #1;
        drive('0);
        mem_ack = 0;
        check_state();
    endtask

    // Memory transaction; ack_at = REQ cycle carrying mem_ack, 0 = never.
    task automatic mem_xact(input logic wr, input int ack_at, input logic [15:0] rd, input logic junk);
        int   cyc;
        logic acked;
        MEM_RD = !wr; MEM_WR = wr;
        sb.push_back({wr, m_mar, m_mdr});
        @(posedge Clk); #1;
        MEM_RD = 0; MEM_WR = 0;
        chk("err_clear_on_start", 32'(MEM_ERR), 0);
        cyc = 0;
        while (mem_req && cyc < 12) begin
            cyc++;
            chk("busy_in_req", 32'(MEM_BUSY), 1);
            mem_ack = (cyc == ack_at);
            mem_rdata = (cyc == ack_at) ? rd : 16'($urandom);
            if (junk) begin
                MEM_RD = 1'($urandom_range(0, 1));
                MEM_WR = 1'($urandom_range(0, 1));
            end
            @(posedge Clk); #1;
        end
        mem_ack = 0; MEM_RD = 0; MEM_WR = 0;
        acked = (ack_at >= 1) && (ack_at <= TO + 1);
        chk("req_cycles", 32'(cyc), acked ? 32'(ack_at) : 32'(TO + 1));
        if (acked && !wr) m_mdr = rd;
        m_err = !acked;
        chk("busy_after_req", 32'(MEM_BUSY), 32'(acked));
        chk("err_after_req", 32'(MEM_ERR), 32'(m_err));
        chk("mdr_after_req", 32'(MDR), 32'(m_mdr));
        @(posedge Clk); #1;
        chk("busy_back_idle", 32'(MEM_BUSY), 0);
        chk("req_back_idle", 32'(mem_req), 0);
    endtask

    task automatic set_mdr(input logic [15:0] v);
        mem_xact(1'b0, 1, v, 1'b0);
    endtask

    task automatic load_ir(input logic [15:0] v);
        ctl_t c;
        set_mdr(v);
        c = '0; c.g_mdr = 1; c.ld_ir = 1;
        rt(c);
    endtask

    // Monitor: compare each new memory request against the scoreboard.
    logic prev_req = 1'b0;
    req_t exp_req;
    always @(negedge Clk) begin
        if (mem_req && !prev_req) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_req: got request addr %h, expected none", mem_addr);
            end else begin
                exp_req = sb.pop_front();
                chk("req_we", 32'(mem_we), 32'(exp_req.we));
                chk("req_addr", 32'(mem_addr), 32'(exp_req.addr));
                chk("req_wdata", 32'(mem_wdata), 32'(exp_req.wdata));
            end
        end
        prev_req = mem_req;
    end

    initial begin
        ctl_t        c;
        logic [31:0] r;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        Reset_al = 1;
        chk("rst_nzp", 32'(NZP), 32'h2);
        chk("rst_pc", 32'(PC), 0);
        check_state();

        // ADD R1,R1,#1 with R1 = 5
        load_ir(16'h1261);
        chk("ir_1261", 32'(IR), 32'h1261);
        set_mdr(16'h0005);
        c = '0; c.g_mdr = 1; c.ld_reg = 1;
        rt(c);
        c = '0; c.g_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.ld_mdr = 1; c.sr1mux = 1;
        rt(c);
        chk("add_result", 32'(MDR), 32'h0006);
        chk("add_nzp", 32'(NZP), 32'h1);
        load_ir(16'h0400);
        c = '0; c.ld_ben = 1;
        rt(c);
        chk("ben_z_vs_p", 32'(BEN), 0);
        load_ir(16'h0200);
        rt(c);
        chk("ben_p_vs_p", 32'(BEN), 1);

        // ADD R2,R2,#-1 with R2 = 0, both widths
        load_ir(16'h14BF);
        c = '0; c.g_alu = 1; c.ld_cc = 1; c.ld_mdr = 1; c.sr1mux = 1;
        rt(c);
        chk("neg_bus16", 32'(MDR), 32'h0000FFFF);
        chk("neg_nzp16", 32'(NZP), 32'h4);
        chk("neg_bus32", mdr32, 32'hFFFFFFFF);
        chk("neg_nzp32", 32'(nzp32), 32'h4);

        // PC wrap
        set_mdr(16'hFFFF);
        c = '0; c.g_mdr = 1; c.ld_pc = 1;
        rt(c);
        c = '0; c.ld_pc = 1; c.pcmux = 2;
        rt(c);
        chk("pc_wrap", 32'(PC), 0);

        // Read with ack in the second request cycle
        set_mdr(16'h3000);
        c = '0; c.g_mdr = 1; c.ld_mar = 1;
        rt(c);
        mem_xact(1'b0, 2, 16'hBEEF, 1'b0);
        chk("read_beef", 32'(MDR), 32'h0000BEEF);

        // Write that times out, then a read clears the error
        mem_xact(1'b1, 0, 16'h0000, 1'b0);
        chk("timeout_err", 32'(MEM_ERR), 1);
        chk("timeout_mdr_kept", 32'(MDR), 32'h0000BEEF);
        mem_xact(1'b0, 1, 16'h1111, 1'b0);
        chk("err_cleared", 32'(MEM_ERR), 0);

        // Simultaneous read and write start
        MEM_RD = 1; MEM_WR = 1;
        @(posedge Clk); #1;
        MEM_RD = 0; MEM_WR = 0;
        m_err = 1;
        chk("dual_no_req", 32'(mem_req), 0);
        chk("dual_err", 32'(MEM_ERR), 1);
        @(posedge Clk); #1;
        chk("dual_still_idle", 32'(mem_req), 0);
        check_state();

        // Randomized mix of register transfers and memory transactions
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                mem_xact(1'($urandom_range(0, 1)), $urandom_range(0, 4), 16'($urandom), 1'b1);
                check_state();
            end else begin
                r = $urandom;
                c = ctl_t'(r[$bits(ctl_t)-1:0]);
                rt(c);
            end
        end

        // Reset in the middle of a request
        MEM_RD = 1;
        @(posedge Clk); #1;
        MEM_RD = 0;
        chk("rst_pre_req", 32'(mem_req), 1);
        #1 Reset_al = 0;
        #1;
        chk("rst_drops_req", 32'(mem_req), 0);
        chk("rst_drops_busy", 32'(MEM_BUSY), 0);
        chk("rst_nzp_mid", 32'(NZP), 32'h2);
        chk("rst_mdr_mid", 32'(MDR), 0);
        @(posedge Clk); #1;
        Reset_al = 1;
        model_reset();
        @(posedge Clk); #1;
        check_state();
        chk("rst_req_after", 32'(mem_req), 0);

        @(posedge Clk); #1;
        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
